// File: rtl/md_scheduler.sv
// md_scheduler: sequences the multi-cycle multiply/divide resource and owns HI/LO.
// Results are computed at issue, held as pending, and committed after a fixed latency.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Abort,
  input  logic        IsMdD,
  output logic        Busy,
  output logic        StallMd,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);
  localparam logic [2:0] OP_MTHI   = 3'd4;
  localparam logic [2:0] OP_MTLO   = 3'd5;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_ok_q;

  logic        issue_ok, accept_md, accept_mthi, accept_mtlo;
  logic        last_cycle, retire;

  logic        is_signed_op, a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur, quot, rem;
  logic [63:0] a_ext, b_ext, product, result;

  // ---------------------------------------------------------------------------
  // Arithmetic: the whole result is formed in the issue cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a value on every path; a missing
  // assignment in a combinational block would infer a latch.
  always_comb begin
    is_signed_op = ~Op[0];

    // The low 64 bits of a product of sign-extended operands are the signed result.
    a_ext   = {{32{is_signed_op & A[31]}}, A};
    b_ext   = {{32{is_signed_op & B[31]}}, B};
    product = a_ext * b_ext;

    // Divide on magnitudes so the -2^31 / -1 corner wraps instead of overflowing.
    a_neg    = is_signed_op & A[31];
    b_neg    = is_signed_op & B[31];
    a_mag    = a_neg ? (32'd0 - A) : A;
    b_mag    = b_neg ? (32'd0 - B) : B;
    div_zero = (B == 32'd0);
    b_safe   = div_zero ? 32'd1 : b_mag;
    uq       = a_mag / b_safe;
    ur       = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    rem      = a_neg ? (32'd0 - ur) : ur;

    result   = Op[1] ? {rem, quot} : product;
  end

  // ---------------------------------------------------------------------------
  // Issue / retire qualification
  // ---------------------------------------------------------------------------
  always_comb begin
    issue_ok    = (state_q == IDLE) & Start & ~Abort;
    accept_md   = issue_ok & ~Op[2];
    accept_mthi = issue_ok & (Op == OP_MTHI);
    accept_mtlo = issue_ok & (Op == OP_MTLO);
    last_cycle  = (state_q == RUN) & (count_q == 5'd1);
    retire      = last_cycle & ~Abort;
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (accept_md) begin
          state_d = RUN;
          count_d = Op[1] ? DIV_LOAD : MULT_LOAD;
        end
      end
      RUN: begin
        if (Abort || (count_q == 5'd1)) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q - 5'd1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending result and architectural HI/LO
  // ---------------------------------------------------------------------------
  // NOTE: the pending result is reset along with HI/LO so a reset can never
  // leave a stale value that a later retire would commit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_ok_q <= 1'b0;
    end else begin
      if (accept_md) begin
        pend_hi_q <= result[63:32];
        pend_lo_q <= result[31:0];
        pend_ok_q <= ~(Op[1] & div_zero);
      end else if ((state_q == RUN) && (Abort || last_cycle)) begin
        pend_ok_q <= 1'b0;
      end

      if (retire && pend_ok_q) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end else begin
        if (accept_mthi) hi_q <= A;
        if (accept_mtlo) lo_q <= A;
      end
    end
  end

  assign Busy    = (state_q == RUN);
  assign StallMd = IsMdD & (Busy | (Start & ~Op[2] & ~Abort));
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: randomized and directed ops against a
// behavioural HI/LO model, with a retire scoreboard drained by a monitor.
module tb_md_scheduler;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        Clk = 1'b0;
  logic        Reset, Start, Abort, IsMdD;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, StallMd;
  logic [31:0] HI, LO;

  md_scheduler #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .Abort  (Abort),
    .IsMdD  (IsMdD),
    .Busy   (Busy),
    .StallMd(StallMd),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } retire_t;

  retire_t     sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] arch_hi = '0;
  logic [31:0] arch_lo = '0;
  bit          mon_en = 1'b0;
  bit          force_ismd = 1'b0;
  int          run_len = 0;
  logic        prev_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle stall and architectural-state checks, retire scoreboard.
  always @(negedge Clk) begin : monitor
    retire_t e;
    logic    exp_stall;
    if (mon_en) begin
      exp_stall = IsMdD & (Busy | (Start & (Op <= 3'd3) & ~Abort));
      check("stall_md", 64'(StallMd), 64'(exp_stall));
      check("hi_arch", 64'(HI), 64'(arch_hi));
      check("lo_arch", 64'(LO), 64'(arch_lo));
      if (Busy === 1'b1) begin
        run_len++;
      end else begin
        if (prev_busy) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_retire: got busy run %0d expected none at %0t", run_len, $time);
          end else begin
            e = sb_q.pop_front();
            check("busy_len", 64'(run_len), 64'(e.len));
            check("retire_hi", 64'(HI), 64'(e.hi));
            check("retire_lo", 64'(LO), 64'(e.lo));
          end
        end
        run_len = 0;
      end
      prev_busy = Busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    IsMdD = force_ismd ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) tick();
  endtask

  // Reference model: architectural effect of one completed operation.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output bit writes);
    longint          sa, sb, p, q, r;
    longint unsigned up;
    writes = 1'b1;
    hi     = '0;
    lo     = '0;
    sa     = longint'($signed(a));
    sb     = longint'($signed(b));
    case (op)
      3'd0: begin
        p  = sa * sb;
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      3'd2: begin
        if (b == 32'd0) writes = 1'b0;
        else begin
          q  = sa / sb;
          r  = sa % sb;
          hi = r[31:0];
          lo = q[31:0];
        end
      end
      3'd3: begin
        if (b == 32'd0) writes = 1'b0;
        else begin
          hi = a % b;
          lo = a / b;
        end
      end
      default: writes = 1'b0;
    endcase
  endfunction

  // One operation; abort_at / reset_at / junk_at name the busy cycle (1-based)
  // on which Abort, Reset or a stray MTHI is applied, 0 for none.
  task automatic md_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int abort_at, input int reset_at, input int junk_at,
                       input bit abort_with_start);
    logic [31:0] rhi, rlo;
    bit          wr;
    bit          done;
    int          n;
    retire_t     rec;
    if (force_ismd) IsMdD = 1'b1;
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    Abort = abort_with_start;

    n = op[1] ? DIV_N : MULT_N;
    model(op, a, b, rhi, rlo, wr);
    rec.len = n;
    rec.hi  = wr ? rhi : arch_hi;
    rec.lo  = wr ? rlo : arch_lo;
    if (abort_at >= 1 && abort_at <= n) begin
      rec.len = abort_at;
      rec.hi  = arch_hi;
      rec.lo  = arch_lo;
    end else if (reset_at >= 1 && reset_at <= n) begin
      rec.len = reset_at;
      rec.hi  = '0;
      rec.lo  = '0;
    end
    if (!abort_with_start && op <= 3'd3) sb_q.push_back(rec);

    tick();
    Start = 1'b0;
    Abort = 1'b0;

    if (abort_with_start) return;
    if (op > 3'd3) begin
      if (op == 3'd4) arch_hi = a;
      else if (op == 3'd5) arch_lo = a;
      return;
    end

    done = 1'b0;
    for (int k = 1; k <= 64 && !done; k++) begin
      if (k == abort_at) Abort = 1'b1;
      if (k == reset_at) Reset = 1'b1;
      if (k == junk_at) begin
        Start = 1'b1;
        Op    = 3'd4;
        A     = 32'hDEAD_BEEF;
      end
      tick();
      Abort = 1'b0;
      Reset = 1'b0;
      Start = 1'b0;
      if (Busy == 1'b0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy after 64 cycles expected idle at %0t", $time);
    end
    arch_hi = rec.hi;
    arch_lo = rec.lo;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'(7 - $urandom_range(0, 14));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Abort = 1'b0;
    IsMdD = 1'b0;
    Op    = 3'd0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge Clk);
    #1;
    Reset  = 1'b0;
    mon_en = 1'b1;
    idle(2);

    force_ismd = 1'b1;
    md_op(3'd0, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, 1'b0);
    force_ismd = 1'b0;

    md_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 1'b0);
    md_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 1'b0);

    md_op(3'd4, 32'h1234_5678, 32'd0, 0, 0, 0, 1'b0);
    md_op(3'd5, 32'h9ABC_DEF0, 32'd0, 0, 0, 0, 1'b0);
    idle(1);

    md_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0, 0, 1'b0);
    idle(1);
    md_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N, 0, 0, 1'b0);

    md_op(3'd4, 32'h55, 32'd0, 0, 0, 0, 1'b0);
    md_op(3'd5, 32'h55, 32'd0, 0, 0, 0, 1'b0);
    md_op(3'd3, 32'h0001_2345, 32'd0, 0, 0, 0, 1'b0);
    md_op(3'd2, 32'h8000_0000, 32'd0, 0, 0, 0, 1'b0);

    md_op(3'd0, 32'h0000_0007, 32'h0000_0009, 0, 2, 0, 1'b0);
    idle(1);

    md_op(3'd0, 32'h0001_0003, 32'hFFFF_0007, 0, 0, 2, 1'b0);
    md_op(3'd1, 32'hCAFE_F00D, 32'h1234_5678, 0, 0, MULT_N, 1'b0);

    md_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 1'b0);
    md_op(3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0, 0, 1'b0);

    md_op(3'd6, 32'h1111_1111, 32'd3, 0, 0, 0, 1'b0);
    md_op(3'd7, 32'h2222_2222, 32'd3, 0, 0, 0, 1'b0);
    md_op(3'd0, 32'h0000_0010, 32'd3, 0, 0, 0, 1'b1);
    md_op(3'd4, 32'h3333_3333, 32'd0, 0, 0, 0, 1'b1);
    idle(2);

    for (int i = 0; i < 80; i++) begin
      logic [2:0] op;
      int         n, sel, ab, rs, jk;
      bit         aws;
      op  = 3'($urandom_range(0, 7));
      n   = op[1] ? DIV_N : MULT_N;
      ab  = 0;
      rs  = 0;
      jk  = 0;
      aws = 1'b0;
      sel = $urandom_range(0, 11);
      if (sel == 0) aws = 1'b1;
      else if (sel <= 2) ab = $urandom_range(1, n);
      else if (sel == 3) rs = $urandom_range(1, n);
      else if (sel <= 5) jk = $urandom_range(1, n);
      md_op(op, pick(), pick(), ab, rs, jk, aws);
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
